// File: rtl/bin_to_bcd_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd_pkg
//  Description : Shared types and constants for the binary-to-BCD converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package bin_to_bcd_pkg;

  // Width of one packed BCD digit
  localparam int BCD_W = 4;

  // Converter control states; encoding 2'd3 is unused and recovers to IDLE
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // ceil(bw * log10(2)) in integer arithmetic: decimal digits needed for 2^bw-1
  function automatic int min_digits(input int bw);
    return (bw * 30103 + 99999) / 100000;
  endfunction

endpackage : bin_to_bcd_pkg
`default_nettype wire

// File: rtl/bcd_digit_adj.sv
`default_nettype none
// ============================================================================
//  Module      : bcd_digit_adj
//  Description : Double-dabble digit correction: add 3 when the digit is >= 5
//                so the following left shift carries into the next digit.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_digit_adj
  import bin_to_bcd_pkg::*;
(
  input  logic [BCD_W-1:0] i_digit,
  output logic [BCD_W-1:0] o_digit
);

  // Purely combinational correction of one digit
  always_comb begin
    o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;
  end

endmodule : bcd_digit_adj
`default_nettype wire

// File: rtl/bin_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : bin_to_bcd
//  Description : Iterative double-dabble binary-to-BCD converter with a
//                valid/ready handshake on both sides. One bit is consumed per
//                SHIFT cycle; a final SHIFT cycle at terminal count publishes
//                the accumulator, so a result takes BIN_WIDTH+1 edges.
//  Revision    : 1.0 - initial release
// ============================================================================
module bin_to_bcd
  import bin_to_bcd_pkg::*;
#(
  parameter int BIN_WIDTH = 32,
  parameter int DIGITS    = 10
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BIN_WIDTH-1:0]        bin_in,
  input  logic                        vld_in,
  output logic                        rdy_in,
  output logic [BCD_W*DIGITS-1:0]     bcd_out,
  output logic [$clog2(DIGITS+1)-1:0] ndigits,
  output logic                        vld_out,
  input  logic                        rdy_out
);

  localparam int CNT_W = $clog2(BIN_WIDTH + 1);
  localparam int NDW   = $clog2(DIGITS + 1);
  localparam int ACC_W = BCD_W * DIGITS;

  // Too few digits would let the accumulator overflow, so refuse to build
  if (DIGITS < min_digits(BIN_WIDTH)) begin : g_param_check
    $error("bin_to_bcd: DIGITS too small for BIN_WIDTH");
  end

  state_t             r_state;
  state_t             w_next;
  logic [ACC_W-1:0]   r_acc;
  logic [BIN_WIDTH-1:0] r_sr;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   r_bcd;
  logic [NDW-1:0]     r_ndig;
  logic [ACC_W-1:0]   w_adj;
  logic [ACC_W-1:0]   w_acc_shift;
  logic [NDW-1:0]     w_ndig;
  logic               w_accept;
  logic               w_last;
  logic               w_unused_msb;

  // One correction cell per digit of the accumulator
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    bcd_digit_adj u_adj (
      .i_digit (r_acc[gi*BCD_W +: BCD_W]),
      .o_digit (w_adj[gi*BCD_W +: BCD_W])
    );
  end

  assign w_accept     = (r_state == ST_IDLE) && vld_in;
  assign w_last       = (r_cnt == CNT_W'(BIN_WIDTH));
  assign w_acc_shift  = {w_adj[ACC_W-2:0], r_sr[BIN_WIDTH-1]};
  // The top accumulator bit can never be set when DIGITS is sufficient
  assign w_unused_msb = w_adj[ACC_W-1];

  // Significant-digit count of the accumulator about to be published
  always_comb begin
    w_ndig = NDW'(1);
    for (int i = 0; i < DIGITS; i++) begin
      if (r_acc[i*BCD_W +: BCD_W] != '0) w_ndig = NDW'(i + 1);
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = ST_IDLE;
    case (r_state)
      ST_IDLE:  w_next = vld_in  ? ST_SHIFT : ST_IDLE;
      ST_SHIFT: w_next = w_last  ? ST_DONE  : ST_SHIFT;
      ST_DONE:  w_next = rdy_out ? ST_IDLE  : ST_DONE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    rdy_in  = (r_state == ST_IDLE);
    vld_out = (r_state == ST_DONE);
  end

  // Datapath: load on accept, shift each SHIFT cycle, publish at terminal count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      r_sr   <= '0;
      r_cnt  <= '0;
      r_bcd  <= '0;
      r_ndig <= NDW'(1);
    end else if (w_accept) begin
      r_acc <= '0;
      r_sr  <= bin_in;
      r_cnt <= '0;
    end else if (r_state == ST_SHIFT) begin
      if (w_last) begin
        r_bcd  <= r_acc;
        r_ndig <= w_ndig;
      end else begin
        r_acc <= w_acc_shift;
        r_sr  <= {r_sr[BIN_WIDTH-2:0], 1'b0};
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign bcd_out = r_bcd;
  assign ndigits = r_ndig;

endmodule : bin_to_bcd
`default_nettype wire

// File: tb/tb_bin_to_bcd.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bin_to_bcd
//  Description : Self-checking bench for bin_to_bcd (directed table, corner
//                sequences and a randomised sweep against a decimal model).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bin_to_bcd;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b0;
  logic [31:0] bin_in = '0;
  logic        vld_in = 1'b0;
  logic        rdy_out = 1'b0;
  logic        rdy_in;
  logic        vld_out;
  logic [39:0] bcd_out;
  logic [3:0]  ndigits;

  int n_tests = 0;
  int n_fail  = 0;
  logic [39:0] prev_bcd = '0;

  typedef struct {
    logic [31:0] bin;
    logic [39:0] bcd;
    logic [3:0]  nd;
  } vec_t;

  vec_t vecs [12];

  bin_to_bcd #(.BIN_WIDTH(32), .DIGITS(10)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bin_in  (bin_in),
    .vld_in  (vld_in),
    .rdy_in  (rdy_in),
    .bcd_out (bcd_out),
    .ndigits (ndigits),
    .vld_out (vld_out),
    .rdy_out (rdy_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [39:0] ref_bcd(input logic [31:0] v);
    longint unsigned x = 64'(v);
    logic [39:0] r = '0;
    for (int i = 0; i < 10; i++) begin
      r[i*4 +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] ref_nd(input logic [39:0] b);
    logic [3:0] n = 4'd1;
    for (int i = 0; i < 10; i++) if (b[i*4 +: 4] != 4'd0) n = 4'(i + 1);
    return n;
  endfunction

  // Called between edges with the DUT in IDLE; accepts on the next rising edge
  task automatic convert(input logic [31:0] v, input logic [39:0] exp_bcd,
                         input logic [3:0] exp_nd, input int stall, input int inject_at);
    int  lat = 41;
    bit  ok_rdy = 1'b1, ok_hold = 1'b1, ok_stall = 1'b1;
    check("ready_before_accept", 64'(rdy_in), 64'd1);
    bin_in = v;
    vld_in = 1'b1;
    @(posedge clk); #1;
    vld_in = 1'b0;
    bin_in = '0;
    for (int k = 1; k <= 40; k++) begin
      if (k == inject_at) begin bin_in = 32'd123; vld_in = 1'b1; end
      if (k == inject_at + 1) begin bin_in = '0; vld_in = 1'b0; end
      if (rdy_in !== 1'b0) ok_rdy = 1'b0;
      if (bcd_out !== prev_bcd) ok_hold = 1'b0;
      @(posedge clk); #1;
      if (vld_out === 1'b1) begin lat = k; break; end
    end
    vld_in = 1'b0;
    check("latency", 64'(lat), 64'd33);
    check("rdy_in_low_busy", 64'(ok_rdy), 64'd1);
    check("bcd_hold_shift", 64'(ok_hold), 64'd1);
    check("rdy_in_low_done", 64'(rdy_in), 64'd0);
    check("bcd_out", 64'(bcd_out), 64'(exp_bcd));
    check("ndigits", 64'(ndigits), 64'(exp_nd));
    rdy_out = 1'b0;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk); #1;
      if (vld_out !== 1'b1 || bcd_out !== exp_bcd || ndigits !== exp_nd || rdy_in !== 1'b0)
        ok_stall = 1'b0;
    end
    if (stall > 0) check("stall_stable", 64'(ok_stall), 64'd1);
    rdy_out = 1'b1;
    @(posedge clk); #1;
    rdy_out = 1'b0;
    check("exit_vld_out", 64'(vld_out), 64'd0);
    check("exit_rdy_in", 64'(rdy_in), 64'd1);
    prev_bcd = exp_bcd;
  endtask

  initial begin
    vecs[0]  = '{32'd0,          40'h0000000000, 4'd1};
    vecs[1]  = '{32'd55,         40'h0000000055, 4'd2};
    vecs[2]  = '{32'd4294967295, 40'h4294967295, 4'd10};
    vecs[3]  = '{32'd1,          40'h0000000001, 4'd1};
    vecs[4]  = '{32'd10,         40'h0000000010, 4'd2};
    vecs[5]  = '{32'd100,        40'h0000000100, 4'd3};
    vecs[6]  = '{32'd999999999,  40'h0999999999, 4'd9};
    vecs[7]  = '{32'd1000000000, 40'h1000000000, 4'd10};
    vecs[8]  = '{32'd2147483648, 40'h2147483648, 4'd10};
    vecs[9]  = '{32'd65535,      40'h0000065535, 4'd5};
    vecs[10] = '{32'd5,          40'h0000000005, 4'd1};
    vecs[11] = '{32'd90,         40'h0000000090, 4'd2};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_rdy_in", 64'(rdy_in), 64'd1);
    check("reset_vld_out", 64'(vld_out), 64'd0);
    check("reset_bcd_out", 64'(bcd_out), 64'd0);
    check("reset_ndigits", 64'(ndigits), 64'd1);
    rst_n = 1'b1;

    // Directed table; first accept lands on the first edge after release
    for (int i = 0; i < 12; i++)
      convert(vecs[i].bin, vecs[i].bcd, vecs[i].nd, i % 3, 0);

    // Long stall on DONE
    convert(32'd9999, 40'h0000009999, 4'd4, 5, 0);

    // A vld_in pulse during SHIFT must be ignored
    convert(32'd7, 40'h0000000007, 4'd1, 0, 5);
    begin
      bit no_extra = 1'b1;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (vld_out !== 1'b0 || rdy_in !== 1'b1) no_extra = 1'b0;
      end
      check("ignored_operand", 64'(no_extra), 64'd1);
    end

    // Reset in the middle of a conversion
    bin_in = 32'd1000;
    vld_in = 1'b1;
    @(posedge clk); #1;
    vld_in = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_vld_out", 64'(vld_out), 64'd0);
    check("midrst_bcd_out", 64'(bcd_out), 64'd0);
    check("midrst_ndigits", 64'(ndigits), 64'd1);
    check("midrst_rdy_in", 64'(rdy_in), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_bcd = '0;
    convert(32'd89, 40'h0000000089, 4'd2, 1, 0);

    // Randomised sweep against the decimal model
    for (int i = 0; i < 1000; i++) begin
      logic [31:0] v;
      case (i % 8)
        0:       v = $urandom_range(0, 99);
        1:       v = $urandom_range(0, 99999);
        default: v = $urandom;
      endcase
      convert(v, ref_bcd(v), ref_nd(ref_bcd(v)), int'($urandom_range(0, 3)), 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_bin_to_bcd
`default_nettype wire
